// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one HD44780-style write bus between two byte
// requesters; each accepted byte becomes a setup / EN pulse / execute-wait sequence.
module lcd_bus_arbiter #(
    parameter int unsigned SETUP_CYC     = 2,
    parameter int unsigned PULSE_CYC     = 25,
    parameter int unsigned EXEC_CYC      = 2_500,
    parameter int unsigned EXEC_LONG_CYC = 100_000,
    parameter int unsigned POWERUP_CYC   = 750_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       busy,
    output logic       grant_id,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    typedef enum logic [2:0] {
        S_POWERUP,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_EXEC
    } state_t;

    localparam logic [31:0] SETUP_LOAD     = 32'(SETUP_CYC - 1);
    localparam logic [31:0] PULSE_LOAD     = 32'(PULSE_CYC - 1);
    localparam logic [31:0] EXEC_LOAD      = 32'(EXEC_CYC - 1);
    localparam logic [31:0] EXEC_LONG_LOAD = 32'(EXEC_LONG_CYC - 1);
    localparam logic [31:0] POWERUP_LOAD   = 32'(POWERUP_CYC - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_id_q, grant_id_d;
    logic        lcd_en_q, lcd_en_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic [7:0]  lcd_data_q, lcd_data_d;

    logic cnt_zero;
    logic winner;
    logic long_exec;

    assign cnt_zero  = (cnt_q == 32'd0);
    // Clear (0x01) and return-home (0x02/0x03) need the long execute wait.
    assign long_exec = !lcd_rs_q && (lcd_data_q[7:2] == 6'd0) && (lcd_data_q[1:0] != 2'd0);
    assign winner    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_data_d   = lcd_data_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            S_POWERUP: begin
                if (cnt_zero) state_d = S_IDLE;
                else          cnt_d   = cnt_q - 32'd1;
            end
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready   = ~winner;
                    req1_ready   = winner;
                    last_grant_d = winner;
                    grant_id_d   = winner;
                    lcd_rs_d     = winner ? req1_rs   : req0_rs;
                    lcd_data_d   = winner ? req1_data : req0_data;
                    cnt_d        = SETUP_LOAD;
                    state_d      = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    cnt_d   = PULSE_LOAD;
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_PULSE: begin
                if (cnt_zero) begin
                    cnt_d   = long_exec ? EXEC_LONG_LOAD : EXEC_LOAD;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_EXEC: begin
                if (cnt_zero) state_d = S_IDLE;
                else          cnt_d   = cnt_q - 32'd1;
            end
            default: begin
                cnt_d   = POWERUP_LOAD;
                state_d = S_POWERUP;
            end
        endcase

        // EN is registered from the next state so the pad sees a clean flop output.
        lcd_en_d = (state_d == S_PULSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_POWERUP;
            cnt_q        <= POWERUP_LOAD;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            lcd_en_q     <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            lcd_en_q     <= lcd_en_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_data_q   <= lcd_data_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_id_q;
    assign lcd_en   = lcd_en_q;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_data = lcd_data_q;

endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

- Shares the single HD44780-style LCD write bus between two byte requesters, e.g. the opcode-label writer and the value/operand writer.
- Performs the power-up wait, then arbitrates round-robin and serialises each accepted byte into a setup / enable-pulse / execute-wait sequence on the LCD pins.
- Sits between the display content generators and the LCD pads, replacing per-writer EN/RS timing logic.

## Interface

- `SETUP_CYC`, default 2: cycles data/RS are stable before EN rises (≥1).
- `PULSE_CYC`, default 25: cycles EN is held high (≥1).
- `EXEC_CYC`, default 2_500: wait after EN falls, normal commands/characters (≥1).
- `EXEC_LONG_CYC`, default 100_000: wait after EN falls for clear/home (≥1).
- `POWERUP_CYC`, default 750_000: wait after reset before the first accept (≥1).
- `clk`, input, 1: single clock; all state on rising edge.
- `rst_n`, input, 1: reset is asynchronous and active-low.
- `req0_valid`, input, 1: requester 0 has a byte.
- `req0_rs`, input, 1: requester 0 RS (0 = command, 1 = data).
- `req0_data`, input, 8: requester 0 byte.
- `req0_ready`, output, 1: requester 0 byte accepted this cycle.
- `req1_valid`, `req1_rs`, `req1_data`, `req1_ready`: same as requester 0.
- `busy`, output, 1: high in every state except IDLE.
- `grant_id`, output, 1: requester of the last accepted byte.
- `lcd_en`, output, 1: LCD enable.
- `lcd_rs`, output, 1: LCD register select.
- `lcd_rw`, output, 1: constant 0 (write only).
- `lcd_data`, output, 8: LCD data bus.

## Operation

- **States:** POWERUP, IDLE, SETUP, PULSE, EXEC.
  - A single down-counter (32-bit) loads N−1 on entry to each timed state.
  - The state advances on the cycle the counter reads 0.
- **POWERUP:** `lcd_en` is 0 and no requests are accepted. After `POWERUP_CYC` cycles the FSM goes to IDLE.
- **IDLE arbitration:** `last_grant` resets to 1.
  - Only one valid requester: that requester wins.
  - Both valid: the requester ≠ `last_grant` wins.
- **Handshake:** `reqN_ready` is combinational and is 1 only in IDLE for the winner. The transfer happens when valid && ready.
  - On the accept edge: latch RS/data into `lcd_rs`/`lcd_data`, update `last_grant` and `grant_id`, go to SETUP.
  - Requesters hold valid/rs/data stable until ready. Deasserting valid before acceptance withdraws the request without side effects.
- **SETUP:** `SETUP_CYC` cycles, EN = 0.
- **PULSE:** `PULSE_CYC` cycles, EN = 1.
- **EXEC:** EN = 0. Waits `EXEC_LONG_CYC` if RS = 0 and data[7:2] = 0 and data[1:0] ≠ 0 (clear 0x01, home 0x02/0x03); otherwise `EXEC_CYC`. Then returns to IDLE.
- `lcd_data`/`lcd_rs` hold the last byte until the next accept.
- **Outputs during a transfer:**
  - `reqN_ready` stays 0 in every non-IDLE state.
  - Requests arriving mid-transfer wait; they are never dropped or reordered.
- **Reset mid-operation:** `lcd_en` drops to 0 asynchronously and the FSM reenters POWERUP. The in-flight byte is abandoned and is not retried.
- **Reset values:**
  - State POWERUP, `busy` 1, `lcd_en` 0, `lcd_rs` 0, `lcd_data` 0x00.
  - `lcd_rw` 0, `grant_id` 0, `req0_ready` 0, `req1_ready` 0.

## Timing

- **Accept:** accept at cycle T (IDLE, valid && ready).
  - SETUP occupies T+1 … T+SETUP_CYC.
  - EN is high T+SETUP_CYC+1 … T+SETUP_CYC+PULSE_CYC.
  - EXEC follows, then IDLE.
- **Next accept:** the earliest next accept is T + SETUP_CYC + PULSE_CYC + EXEC + 1.
  - EXEC is `EXEC_CYC` or `EXEC_LONG_CYC`.
  - Defaults, normal byte: 2528 cycles/byte.
- **Data stability:** data/RS are stable from T+1 until the next accept edge, so they are stable across the whole EN pulse and the EN falling edge.
- **First accept after reset:** earliest at cycle `POWERUP_CYC` after `rst_n` rises (counting the first clk edge after release as cycle 1).
- **Back-to-back:** with continuous valid on both ports, grants alternate 0, 1, 0, 1, …
- **No combinational paths:** no path from `reqN_valid` to any `lcd_*` output.

## Test plan

Parameters for all benches: `SETUP_CYC`=2, `PULSE_CYC`=4, `EXEC_CYC`=8, `EXEC_LONG_CYC`=20, `POWERUP_CYC`=10.

- **Power-up:** hold `req0_valid`=1 (rs=1, 0x41) from reset release.
  - `req0_ready`=0 and `busy`=1 for 10 cycles.
  - Ready then pulses once; `lcd_data`=0x41, `lcd_rs`=1.
  - EN is high exactly 4 cycles, starting 3 cycles after accept.
- **Normal vs long wait:** send rs=0 0x06, then rs=0 0x01, then rs=0 0x02, then rs=1 0x01, all from req0 held valid.
  - Accept-to-accept spacing is 15, 27, 27, 15 cycles.
- **Round-robin:** both valid continuously with distinct bytes (req0 0x30, req1 0x31), 4 transfers.
  - `grant_id` sequence 0, 1, 0, 1.
  - `lcd_data` sequence 0x30, 0x31, 0x30, 0x31.
- **Late arrival:** req1 asserts valid during req0's PULSE state.
  - `req1_ready` stays 0 until IDLE, then is accepted on the first IDLE cycle.
  - req0's byte is unchanged on the bus through EXEC.
- **Async reset mid-pulse:** assert `rst_n`=0 while `lcd_en`=1.
  - `lcd_en` goes 0 in the same cycle without waiting for a clock edge.
  - After release: `busy`=1, 10-cycle POWERUP, `lcd_data`=0x00, and the abandoned byte is not resent.
- **Withdrawn request:** req0 valid for 1 cycle during EXEC, then deasserted before IDLE.
  - No accept; `lcd_en` stays 0 and `busy`=0 afterwards.
